decode_ctrl_stage: RTL and testbench

//  Registered, buffered successor to the combinational control ROM. Decodes each RV32I
//  (+ optional M-extension) instruction into rv32i_control_word plus mul/div and illegal

---
 rtl/decode_ctrl_stage.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32I (+ optional M) decode stage with a skid FIFO.
// Each instruction accepted from fetch is decoded into an rv32i_control_word (plus
// mul/div and illegal flags) and queued. Execute consumes entries from the head.
//   clk, rst (sync, active-low), flush      : clock / reset / discard queued entries
//   in_valid, in_ready, in_instr, in_pc      : fetch-side handshake and payload
//   out_valid, out_ready, out_ctrl, out_pc,
//   out_instr, out_muldiv, out_mdop,
//   out_illegal                              : execute-side handshake and head entry
//   illegal_count                            : saturating count of accepted illegal entries

package pcmux;
  typedef enum logic [1:0] {pc_plus4 = 2'b00, alu_out = 2'b01, alu_mod2 = 2'b10} pcmux_sel_t;
endpackage

package cmpmux;
  typedef enum logic {rs2_out = 1'b0, i_imm = 1'b1} cmpmux_sel_t;
endpackage

package alumux;
  typedef enum logic {rs1_out = 1'b0, pc_out = 1'b1} alumux1_sel_t;
  typedef enum logic [2:0] {
    i_imm = 3'd0, u_imm = 3'd1, b_imm = 3'd2, s_imm = 3'd3, j_imm = 3'd4, rs2_out = 3'd5
  } alumux2_sel_t;
endpackage

package regfilemux;
  typedef enum logic [3:0] {
    alu_out = 4'd0, br_en = 4'd1, u_imm = 4'd2, lw = 4'd3, pc_plus4 = 4'd4,
    lb = 4'd5, lbu = 4'd6, lh = 4'd7, lhu = 4'd8
  } regfilemux_sel_t;
endpackage

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111, op_jalr = 7'b1100111,
    op_br = 7'b1100011, op_load = 7'b0000011, op_store = 7'b0100011, op_imm = 7'b0010011,
    op_reg = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef struct packed {
    logic [6:0]                   opcode;
    alu_ops                       aluop;
    branch_funct3_t               cmpop;
    pcmux::pcmux_sel_t            pcmux_sel;
    cmpmux::cmpmux_sel_t          cmpmux_sel;
    alumux::alumux1_sel_t         alumux1_sel;
    alumux::alumux2_sel_t         alumux2_sel;
    regfilemux::regfilemux_sel_t  regfilemux_sel;
    logic [3:0]                   byte_enable;
    logic                         regfile_load;
    logic                         mem_read;
    logic                         mem_write;
  } rv32i_control_word;
endpackage

module decode_ctrl_stage
  import rv32i_types::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2,
  parameter int ENABLE_M   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output rv32i_control_word out_ctrl,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic              out_muldiv,
  output logic [2:0]        out_mdop,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [XLEN-1:0]   pc;
    logic [31:0]       instr;
    logic              muldiv;
    logic [2:0]        mdop;
    logic              illegal;
  } entry_t;

  entry_t            mem_q [SKID_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

  rv32i_control_word dec_ctrl;
  logic              dec_muldiv, dec_illegal;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              push, pop;
  entry_t            head;

  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Decode; any illegal encoding collapses the word to zero except the opcode field.
  always_comb begin
    dec_ctrl                = '0;
    dec_ctrl.opcode         = in_instr[6:0];
    dec_ctrl.aluop          = alu_add;
    dec_ctrl.cmpop          = beq;
    dec_ctrl.pcmux_sel      = pcmux::pc_plus4;
    dec_ctrl.cmpmux_sel     = cmpmux::rs2_out;
    dec_ctrl.alumux1_sel    = alumux::rs1_out;
    dec_ctrl.alumux2_sel    = alumux::i_imm;
    dec_ctrl.regfilemux_sel = regfilemux::alu_out;
    dec_ctrl.byte_enable    = 4'b1111;
    dec_muldiv              = 1'b0;
    dec_illegal             = 1'b0;
    case (in_instr[6:0])
      op_lui: begin
        dec_ctrl.regfile_load   = 1'b1;
        dec_ctrl.regfilemux_sel = regfilemux::u_imm;
      end
      op_auipc: begin
        dec_ctrl.regfile_load = 1'b1;
        dec_ctrl.alumux1_sel  = alumux::pc_out;
        dec_ctrl.alumux2_sel  = alumux::u_imm;
      end
      op_jal: begin
        dec_ctrl.regfile_load   = 1'b1;
        dec_ctrl.alumux1_sel    = alumux::pc_out;
        dec_ctrl.alumux2_sel    = alumux::j_imm;
        dec_ctrl.pcmux_sel      = pcmux::alu_out;
        dec_ctrl.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_jalr: begin
        dec_illegal             = (funct3 != 3'b000);
        dec_ctrl.regfile_load   = 1'b1;
        dec_ctrl.pcmux_sel      = pcmux::alu_mod2;
        dec_ctrl.regfilemux_sel = regfilemux::pc_plus4;
      end
      op_br: begin
        dec_illegal          = (funct3 == 3'b010) || (funct3 == 3'b011);
        dec_ctrl.cmpop       = branch_funct3_t'(funct3);
        dec_ctrl.alumux1_sel = alumux::pc_out;
        dec_ctrl.alumux2_sel = alumux::b_imm;
      end
      op_load: begin
        dec_ctrl.regfile_load = 1'b1;
        dec_ctrl.mem_read     = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl.regfilemux_sel = regfilemux::lb;
          3'b001:  dec_ctrl.regfilemux_sel = regfilemux::lh;
          3'b010:  dec_ctrl.regfilemux_sel = regfilemux::lw;
          3'b100:  dec_ctrl.regfilemux_sel = regfilemux::lbu;
          3'b101:  dec_ctrl.regfilemux_sel = regfilemux::lhu;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_store: begin
        dec_ctrl.mem_write   = 1'b1;
        dec_ctrl.alumux2_sel = alumux::s_imm;
        case (funct3)
          3'b000:  dec_ctrl.byte_enable = 4'b0001;
          3'b001:  dec_ctrl.byte_enable = 4'b0011;
          3'b010:  dec_ctrl.byte_enable = 4'b1111;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_imm: begin
        dec_ctrl.regfile_load = 1'b1;
        case (funct3)
          3'b001: begin
            dec_illegal    = (funct7 != 7'b0000000);
            dec_ctrl.aluop = alu_sll;
          end
          3'b101: begin
            dec_illegal    = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            dec_ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
          end
          3'b010, 3'b011: begin
            dec_ctrl.cmpop          = funct3[0] ? bltu : blt;
            dec_ctrl.cmpmux_sel     = cmpmux::i_imm;
            dec_ctrl.regfilemux_sel = regfilemux::br_en;
          end
          default: dec_ctrl.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        dec_ctrl.regfile_load = 1'b1;
        if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          dec_muldiv = 1'b1;
        end else if (funct7 == 7'b0000000 ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_ctrl.alumux2_sel = alumux::rs2_out;
          case (funct3)
            3'b000: dec_ctrl.aluop = funct7[5] ? alu_sub : alu_add;
            3'b101: dec_ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            3'b010, 3'b011: begin
              dec_ctrl.cmpop          = funct3[0] ? bltu : blt;
              dec_ctrl.regfilemux_sel = regfilemux::br_en;
            end
            default: dec_ctrl.aluop = alu_ops'(funct3);
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl        = '0;
      dec_ctrl.opcode = in_instr[6:0];
      dec_muldiv      = 1'b0;
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  // in_ready depends only on registered occupancy and rst, never on out_ready.
  assign in_ready  = rst && (count_q < CW'(SKID_DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (push && dec_illegal && (illegal_cnt_q != '1)) illegal_cnt_d = illegal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{ctrl: dec_ctrl, pc: in_pc, instr: in_instr, muldiv: dec_muldiv,
                            mdop: dec_muldiv ? funct3 : 3'b000, illegal: dec_illegal};
    end
  end

  // Outputs read as zero whenever the queue is empty, so reset clears them without
  // needing to reset the storage array.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_ctrl      = head.ctrl;
  assign out_pc        = head.pc;
  assign out_instr     = head.instr;
  assign out_muldiv    = head.muldiv;
  assign out_mdop      = head.mdop;
  assign out_illegal   = head.illegal;
  assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;
  import rv32i_types::*;

  localparam int DEPTH    = 2;
  localparam int CNTA_MAX = 65535;
  localparam int CNTB_MAX = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic              a_in_ready, a_out_valid, a_out_muldiv, a_out_illegal;
  rv32i_control_word a_out_ctrl;
  logic [31:0]       a_out_pc, a_out_instr;
  logic [2:0]        a_out_mdop;
  logic [15:0]       a_cnt;

  logic              b_in_ready, b_out_valid, b_out_muldiv, b_out_illegal;
  rv32i_control_word b_out_ctrl;
  logic [31:0]       b_out_pc, b_out_instr;
  logic [2:0]        b_out_mdop;
  logic [2:0]        b_cnt;

  decode_ctrl_stage #(.XLEN(32), .SKID_DEPTH(DEPTH), .ENABLE_M(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .out_muldiv(a_out_muldiv), .out_mdop(a_out_mdop), .out_illegal(a_out_illegal),
    .illegal_count(a_cnt)
  );

  decode_ctrl_stage #(.XLEN(32), .SKID_DEPTH(DEPTH), .ENABLE_M(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .out_muldiv(b_out_muldiv), .out_mdop(b_out_mdop), .out_illegal(b_out_illegal),
    .illegal_count(b_cnt)
  );

  typedef struct {
    rv32i_control_word ctrl;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              md;
    logic [2:0]        mdop;
    logic              ill;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned cnta = 0, cntb = 0;
  int unsigned passes = 0, fails = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic alu_ops alu_of(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0:    return alt ? alu_sub : alu_add;
      3'd1:    return alu_sll;
      3'd4:    return alu_xor;
      3'd5:    return alt ? alu_sra : alu_srl;
      3'd6:    return alu_or;
      default: return alu_and;
    endcase
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input bit men);
    exp_t       e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit         bad;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e.pc = pc; e.instr = ins; e.md = 1'b0; e.mdop = 3'd0; bad = 1'b0;
    e.ctrl = '0;
    e.ctrl.opcode         = op;
    e.ctrl.aluop          = alu_add;
    e.ctrl.cmpop          = beq;
    e.ctrl.pcmux_sel      = pcmux::pc_plus4;
    e.ctrl.cmpmux_sel     = cmpmux::rs2_out;
    e.ctrl.alumux1_sel    = alumux::rs1_out;
    e.ctrl.alumux2_sel    = alumux::i_imm;
    e.ctrl.regfilemux_sel = regfilemux::alu_out;
    e.ctrl.byte_enable    = 4'hF;
    if (op == 7'h37) begin
      e.ctrl.regfile_load = 1'b1; e.ctrl.regfilemux_sel = regfilemux::u_imm;
    end else if (op == 7'h17) begin
      e.ctrl.regfile_load = 1'b1; e.ctrl.alumux1_sel = alumux::pc_out;
      e.ctrl.alumux2_sel = alumux::u_imm;
    end else if (op == 7'h6F) begin
      e.ctrl.regfile_load = 1'b1; e.ctrl.alumux1_sel = alumux::pc_out;
      e.ctrl.alumux2_sel = alumux::j_imm; e.ctrl.pcmux_sel = pcmux::alu_out;
      e.ctrl.regfilemux_sel = regfilemux::pc_plus4;
    end else if (op == 7'h67) begin
      bad = (f3 != 0);
      e.ctrl.regfile_load = 1'b1; e.ctrl.pcmux_sel = pcmux::alu_mod2;
      e.ctrl.regfilemux_sel = regfilemux::pc_plus4;
    end else if (op == 7'h63) begin
      bad = (f3 == 2 || f3 == 3);
      if (!bad) e.ctrl.cmpop = branch_funct3_t'(f3);
      e.ctrl.alumux1_sel = alumux::pc_out; e.ctrl.alumux2_sel = alumux::b_imm;
    end else if (op == 7'h03) begin
      bad = (f3 == 3 || f3 > 5);
      e.ctrl.regfile_load = 1'b1; e.ctrl.mem_read = 1'b1;
      if (f3 == 0) e.ctrl.regfilemux_sel = regfilemux::lb;
      if (f3 == 1) e.ctrl.regfilemux_sel = regfilemux::lh;
      if (f3 == 2) e.ctrl.regfilemux_sel = regfilemux::lw;
      if (f3 == 4) e.ctrl.regfilemux_sel = regfilemux::lbu;
      if (f3 == 5) e.ctrl.regfilemux_sel = regfilemux::lhu;
    end else if (op == 7'h23) begin
      bad = (f3 > 2);
      e.ctrl.mem_write = 1'b1; e.ctrl.alumux2_sel = alumux::s_imm;
      e.ctrl.byte_enable = (f3 == 0) ? 4'h1 : (f3 == 1) ? 4'h3 : 4'hF;
    end else if (op == 7'h13) begin
      e.ctrl.regfile_load = 1'b1;
      if (f3 == 1) bad = (f7 != 0);
      if (f3 == 5) bad = !(f7 == 7'h00 || f7 == 7'h20);
      if (f3 == 2 || f3 == 3) begin
        e.ctrl.cmpop = (f3 == 3) ? bltu : blt;
        e.ctrl.cmpmux_sel = cmpmux::i_imm;
        e.ctrl.regfilemux_sel = regfilemux::br_en;
      end else begin
        e.ctrl.aluop = alu_of(f3, (f3 == 5) && f7[5]);
      end
    end else if (op == 7'h33) begin
      e.ctrl.regfile_load = 1'b1;
      if (men && f7 == 7'h01) begin
        e.md = 1'b1; e.mdop = f3;
      end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
        e.ctrl.alumux2_sel = alumux::rs2_out;
        if (f3 == 2 || f3 == 3) begin
          e.ctrl.cmpop = (f3 == 3) ? bltu : blt;
          e.ctrl.regfilemux_sel = regfilemux::br_en;
        end else begin
          e.ctrl.aluop = alu_of(f3, f7 == 7'h20);
        end
      end else begin
        bad = 1'b1;
      end
    end else begin
      bad = 1'b1;
    end
    if (bad) begin
      e.ctrl = '0; e.ctrl.opcode = op; e.md = 1'b0; e.mdop = 3'd0;
    end
    e.ill = bad;
    return e;
  endfunction

  task automatic check_all();
    exp_t ea, eb;
    chk("a.in_ready", a_in_ready, rst && (qa.size() < DEPTH));
    chk("b.in_ready", b_in_ready, rst && (qb.size() < DEPTH));
    chk("a.out_valid", a_out_valid, qa.size() != 0);
    chk("b.out_valid", b_out_valid, qb.size() != 0);
    chk("a.illegal_count", a_cnt, cnta);
    chk("b.illegal_count", b_cnt, cntb);
    if (qa.size() != 0) begin
      ea = qa[0];
      chk("a.ctrl", a_out_ctrl, ea.ctrl);
      chk("a.pc", a_out_pc, ea.pc);
      chk("a.instr", a_out_instr, ea.instr);
      chk("a.muldiv", a_out_muldiv, ea.md);
      chk("a.mdop", a_out_mdop, ea.mdop);
      chk("a.illegal", a_out_illegal, ea.ill);
    end
    if (qb.size() != 0) begin
      eb = qb[0];
      chk("b.ctrl", b_out_ctrl, eb.ctrl);
      chk("b.pc", b_out_pc, eb.pc);
      chk("b.muldiv", b_out_muldiv, eb.md);
      chk("b.illegal", b_out_illegal, eb.ill);
    end
  endtask

  // One clock: update the reference queues with the inputs present at the edge,
  // then compare just after the edge.
  task automatic step();
    exp_t ea, eb;
    bit   push, pop;
    @(posedge clk);
    if (!rst) begin
      qa.delete(); qb.delete(); cnta = 0; cntb = 0;
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      push = in_valid && (qa.size() < DEPTH);
      pop  = (qa.size() != 0) && out_ready;
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (push) begin
        ea = ref_dec(in_instr, in_pc, 1'b1);
        eb = ref_dec(in_instr, in_pc, 1'b0);
        qa.push_back(ea);
        qb.push_back(eb);
        if (ea.ill && cnta < CNTA_MAX) cnta++;
        if (eb.ill && cntb < CNTB_MAX) cntb++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [6:0]  f7s [4];
    logic [31:0] r;
    int unsigned k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h05};
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) r[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
    return r;
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset state.
    step(); step();
    chk("rst.ctrl", a_out_ctrl, 0);
    chk("rst.pc", a_out_pc, 0);
    chk("rst.instr", a_out_instr, 0);
    chk("rst.mdop", a_out_mdop, 0);
    chk("rst.in_ready", a_in_ready, 0);
    rst = 1'b1;

    // add x1,x2,x3 with out_ready high: one-cycle latency, then empty.
    drive(1'b1, 32'h003100B3, 32'h0, 1'b1);
    step();
    chk("add.valid", a_out_valid, 1);
    chk("add.aluop", a_out_ctrl.aluop, alu_add);
    chk("add.alumux2", a_out_ctrl.alumux2_sel, alumux::rs2_out);
    chk("add.regfile_load", a_out_ctrl.regfile_load, 1);
    chk("add.illegal", a_out_illegal, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("add.drained", a_out_valid, 0);

    // Back-pressure: two accepted, third held off, outputs stable, drained in order.
    drive(1'b1, 32'h00100093, 32'h0, 1'b0); step();
    drive(1'b1, 32'h0000A103, 32'h4, 1'b0); step();
    chk("bp.in_ready_full", a_in_ready, 0);
    drive(1'b1, 32'h000000EF, 32'h8, 1'b0); step();
    chk("bp.hold_pc", a_out_pc, 32'h0);
    step();
    chk("bp.hold_pc2", a_out_pc, 32'h0);
    out_ready = 1'b1; step();
    chk("bp.second_pc", a_out_pc, 32'h4);
    step();
    chk("bp.third_pc", a_out_pc, 32'h8);
    in_valid = 1'b0; step();
    chk("bp.empty", a_out_valid, 0);

    // Fresh reset, then M-extension and illegal counting / saturation.
    rst = 1'b0; step(); rst = 1'b1;
    drive(1'b1, 32'h02A30333, 32'h100, 1'b1); step();
    chk("mul.a_muldiv", a_out_muldiv, 1);
    chk("mul.a_mdop", a_out_mdop, 0);
    chk("mul.b_illegal", b_out_illegal, 1);
    chk("mul.b_count", b_cnt, 1);
    drive(1'b1, 32'h00003003, 32'h104, 1'b1); step();
    chk("ld3.illegal", a_out_illegal, 1);
    chk("ld3.regfile_load", a_out_ctrl.regfile_load, 0);
    drive(1'b1, 32'h0000007F, 32'h108, 1'b1); step();
    chk("op7f.illegal", a_out_illegal, 1);
    chk("op7f.regfile_load", a_out_ctrl.regfile_load, 0);
    chk("op7f.a_count", a_cnt, 2);
    for (int i = 0; i < 6; i++) step();
    chk("sat.b_count", b_cnt, 7);
    chk("sat.a_count", a_cnt, 8);
    in_valid = 1'b0; step();

    // Flush with two queued entries and a concurrent illegal push.
    drive(1'b1, 32'h00100093, 32'h200, 1'b0); step();
    drive(1'b1, 32'h00200113, 32'h204, 1'b0); step();
    flush = 1'b1;
    drive(1'b1, 32'h0000007F, 32'h208, 1'b1); step();
    flush = 1'b0;
    chk("flush.valid", a_out_valid, 0);
    chk("flush.a_count", a_cnt, 8);
    chk("flush.in_ready", a_in_ready, 1);

    // Reset mid-stream.
    drive(1'b1, 32'h00100093, 32'h300, 1'b0); step();
    rst = 1'b0; step();
    chk("midrst.valid", a_out_valid, 0);
    chk("midrst.pc", a_out_pc, 0);
    chk("midrst.in_ready", a_in_ready, 0);
    chk("midrst.count", a_cnt, 0);
    rst = 1'b1;

    // Randomized traffic against the reference queues.
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom, 2'b00};
      step();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
